debayer_frame_sequencer: RTL and testbench



---
 rtl/debayer_frame_sequencer.sv | 103 ++++++++++
 tb/tb_debayer_frame_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debayer_frame_sequencer.sv
// debayer_frame_sequencer: frame-locked Avalon-ST control + video packet sequencer
module debayer_frame_sequencer #(
  parameter int WID = 1920,
  parameter int HEI = 1080,
  parameter int DW  = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [15:0]   width,
  input  logic [15:0]   height,
  input  logic [3:0]    interlacing,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [DW-1:0] source_data,
  output logic          source_valid,
  input  logic          source_ready,
  output logic          source_sop,
  output logic          source_eop,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);
  typedef enum logic [1:0] {IDLE, CTRL, VHDR, VIDEO} state_t;
  state_t      state_q, state_d;
  logic [15:0] w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [3:0]  intl_q, intl_d;
  logic [1:0]  beat_q, beat_d;
  logic        cfg_err_q, cfg_err_d;
  logic        xfer, last_col, last_row, start_ok;
  logic [23:0] ctrl_data;
  always_comb begin
    last_col     = col_q == w_q - 16'd1;
    last_row     = row_q == h_q - 16'd1;
    start_ok     = (width != '0) && (height != '0);
    ctrl_data    = beat_q == 2'd0 ? 24'h00000F :
                   beat_q == 2'd1 ? {4'h0, w_q[7:4], 4'h0, w_q[11:8], 4'h0, w_q[15:12]} :
                   beat_q == 2'd2 ? {4'h0, h_q[11:8], 4'h0, h_q[15:12], 4'h0, w_q[3:0]} :
                                    {4'h0, intl_q, 4'h0, h_q[3:0], 4'h0, h_q[7:4]};
    source_valid = state_q == VIDEO ? pix_valid : state_q != IDLE;
    pix_ready    = state_q == VIDEO && source_ready;
    source_data  = state_q == VIDEO ? pix_data : state_q == CTRL ? DW'(ctrl_data) : '0;
    source_sop   = (state_q == CTRL && beat_q == 2'd0) || state_q == VHDR;
    source_eop   = (state_q == CTRL && beat_q == 2'd3) || (state_q == VIDEO && last_col && last_row);
    xfer         = source_valid && source_ready;
    frame_done   = state_q == VIDEO && xfer && source_eop;
    busy         = state_q != IDLE;
    cfg_err      = cfg_err_q;
  end
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    intl_d    = intl_q;
    beat_d    = beat_q;
    col_d     = col_q;
    row_d     = row_q;
    cfg_err_d = cfg_err_q;
    // A frame start happens from IDLE or directly off the last video beat
    if (go && (state_q == IDLE || frame_done)) begin
      w_d       = width;
      h_d       = height;
      intl_d    = interlacing;
      beat_d    = 2'd0;
      cfg_err_d = !start_ok;
      state_d   = start_ok ? CTRL : IDLE;
    end else if (frame_done) begin
      state_d = IDLE;
    end else if (state_q == CTRL && xfer) begin
      beat_d  = beat_q + 2'd1;
      state_d = beat_q == 2'd3 ? VHDR : CTRL;
    end else if (state_q == VHDR && xfer) begin
      state_d = VIDEO;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == VIDEO && xfer) begin
      col_d = last_col ? 16'd0 : col_q + 16'd1;
      row_d = last_col ? row_q + 16'd1 : row_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= 16'(WID);
      h_q       <= 16'(HEI);
      intl_q    <= '0;
      beat_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      intl_q    <= intl_d;
      beat_q    <= beat_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cfg_err_q <= cfg_err_d;
    end
  end
endmodule

// File: tb/tb_debayer_frame_sequencer.sv
// tb_debayer_frame_sequencer: randomized stall stimulus against a beat-index frame model
module tb_debayer_frame_sequencer;
  logic        clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic [15:0] width = 16'd4, height = 16'd2;
  logic [3:0]  interlacing = 4'h0;
  logic [23:0] pix_data = '0, source_data;
  logic        pix_valid = 1'b0, pix_ready, source_valid, source_ready = 1'b0;
  logic        source_sop, source_eop, busy, frame_done, cfg_err;
  int          n_chk = 0, n_pass = 0, rdy_stall = 0, pv_stall = 0;
  bit          idle_m = 1'b1, cfg_m = 1'b0;
  int unsigned fw = 0, fh = 0, fi = 0, vid_n = 0, pix_n = 0, fd_m = 0, fd_dut = 0;
  longint      b = 0;
  always #5 clk = ~clk;
  debayer_frame_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .width(width), .height(height), .interlacing(interlacing),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );
  function automatic logic [23:0] pix_f(input int unsigned n);
    logic [31:0] t;
    t = (n + 32'd1) * 32'h9E3779B1;
    return t[31:8];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  // One clock: drive at negedge, compare before posedge, advance model after it
  task automatic cyc();
    logic vid, last, es, ee, xfer, hs;
    logic [23:0] ed;
    @(negedge clk);
    source_ready = !rst && ($urandom_range(99) >= rdy_stall);
    pix_valid    = !rst && ($urandom_range(99) >= pv_stall);
    pix_data     = pix_f(pix_n);
    #1;
    vid  = b >= 5;
    last = vid && (b - 5 == longint'(fw) * fh - 1);
    es   = b == 0 || b == 4;
    ee   = b == 3 || last;
    if (b == 0) ed = 24'h00000F;
    else if (b == 1) ed = 24'((((fw >> 4) & 15) << 16) | (((fw >> 8) & 15) << 8) | ((fw >> 12) & 15));
    else if (b == 2) ed = 24'((((fh >> 8) & 15) << 16) | (((fh >> 12) & 15) << 8) | (fw & 15));
    else if (b == 3) ed = 24'(((fi & 15) << 16) | ((fh & 15) << 8) | ((fh >> 4) & 15));
    else if (b == 4) ed = 24'h0;
    else ed = pix_f(vid_n);
    xfer = source_valid && source_ready;
    hs   = pix_valid && pix_ready;
    if (frame_done === 1'b1) fd_dut++;
    if (idle_m) begin
      chk("idle_valid", source_valid, 0);
      chk("idle_pix_ready", pix_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sop_eop", {source_sop, source_eop}, 0);
    end else begin
      chk("busy", busy, 1);
      if (!vid) begin
        chk("ctl_valid", source_valid, 1);
        chk("ctl_pix_ready", pix_ready, 0);
      end else begin
        chk("vid_valid", source_valid, pix_valid);
        chk("vid_pix_ready", pix_ready, source_ready);
      end
      if (source_valid) begin
        chk("data", source_data, ed);
        chk("sop", source_sop, es);
        chk("eop", source_eop, ee);
      end
    end
    chk("cfg_err", cfg_err, cfg_m);
    chk("frame_done", frame_done, !idle_m && xfer && last);
    @(posedge clk);
    #1;
    if (rst) begin
      idle_m = 1'b1;
      cfg_m  = 1'b0;
      b      = 0;
    end else begin
      if (!idle_m && xfer) begin
        if (vid) vid_n++;
        if (last) begin
          fd_m++;
          idle_m = 1'b1;
        end else b++;
      end
      if (idle_m && go) begin
        fw = width;
        fh = height;
        fi = interlacing;
        if (width != 0 && height != 0) begin
          idle_m = 1'b0;
          b      = 0;
          cfg_m  = 1'b0;
        end else cfg_m = 1'b1;
      end
      if (hs) pix_n++;
    end
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic until_idle(input int bound);
    for (int i = 0; i < bound && !idle_m; i++) cyc();
    chk("idle_timeout", idle_m, 1);
  endtask
  task automatic pulse_go();
    go = 1'b1;
    cyc();
    go = 1'b0;
  endtask
  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int unsigned p0, f0;
    run(3);
    rst = 1'b0;
    run(3);
    // small frame, no stalls
    p0 = pix_n; f0 = fd_dut;
    width = 16'd4; height = 16'd2; interlacing = 4'h0;
    pulse_go();
    until_idle(40);
    chk("s1_pixels", pix_n - p0, 8);
    chk("s1_frame_done", fd_dut - f0, 1);
    // full-HD control packet, then reset during video
    width = 16'd1920; height = 16'd1080; interlacing = 4'h3;
    pulse_go();
    for (int i = 0; i < 50 && b < 10; i++) cyc();
    chk("s2_reached_video", b >= 10, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("s2_rst_valid", source_valid, 0);
    chk("s2_rst_busy", busy, 0);
    width = 16'd4; height = 16'd2; interlacing = 4'h0;
    pulse_go();
    until_idle(40);
    // random stalls on 3x3
    rdy_stall = 40; pv_stall = 40;
    p0 = pix_n; f0 = fd_dut;
    width = 16'd3; height = 16'd3; interlacing = 4'h5;
    pulse_go();
    until_idle(400);
    chk("s3_pixels", pix_n - p0, 9);
    chk("s3_frame_done", fd_dut - f0, 1);
    // continuous frames with a mid-frame width change, then go dropped
    rdy_stall = 20; pv_stall = 20;
    p0 = pix_n; f0 = fd_dut;
    width = 16'd5; height = 16'd2;
    go = 1'b1;
    run(8);
    width = 16'd2;
    for (int i = 0; i < 400 && fd_m == f0 + fd_m - fd_dut && fd_dut == f0; i++) cyc();
    chk("s4_frame1_done", fd_dut - f0, 1);
    run(6);
    go = 1'b0;
    until_idle(400);
    chk("s4_pixels", pix_n - p0, 14);
    chk("s4_frame_done", fd_dut - f0, 2);
    chk("s4_busy", busy, 0);
    // zero width rejected, then accepted
    rdy_stall = 0; pv_stall = 0;
    width = 16'd0; height = 16'd2;
    go = 1'b1;
    run(5);
    chk("s5_cfg_set", cfg_err, 1);
    chk("s5_no_valid", source_valid, 0);
    width = 16'd4;
    cyc();
    go = 1'b0;
    chk("s5_cfg_clr", cfg_err, 0);
    chk("s5_started", busy, 1);
    until_idle(40);
    // random small frames including 1x1
    for (int k = 0; k < 8; k++) begin
      width  = k == 0 ? 16'd1 : 16'($urandom_range(4, 1));
      height = k == 0 ? 16'd1 : 16'($urandom_range(3, 1));
      interlacing = 4'($urandom_range(15));
      rdy_stall = int'($urandom_range(50));
      pv_stall  = int'($urandom_range(50));
      p0 = pix_n; f0 = fd_dut;
      pulse_go();
      until_idle(400);
      chk("s6_pixels", pix_n - p0, 32'(width) * 32'(height));
      chk("s6_frame_done", fd_dut - f0, 1);
    end
    chk("model_frames", fd_dut, fd_m);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
